// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - Shared types and seven-segment patterns for the FND scan controller.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam int ROW_COUNT = 8;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Patterns are {A,B,C,D,E,F,G}
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // A digit is suppressed only while every digit to its left is too; digit 0 always shows.
  function automatic logic [ROW_COUNT-1:0] lz_mask(
    input logic [4*ROW_COUNT-1:0] d,
    input logic [ROW_COUNT-1:0]   p
  );
    logic [ROW_COUNT-1:0] m;
    logic                 above;
    m     = '0;
    above = 1'b1;
    for (int i = ROW_COUNT - 1; i >= 1; i--) begin
      above = above && (d[4*i +: 4] == 4'h0) && !p[i];
      m[i]  = above;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - Combinational 4-bit code plus decimal point to {A..G,DP}.
module seg7_encode
  import fnd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {SEG_TABLE[code], dp};

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 8-digit seven-segment scan scheduler with per-frame snapshot.
// Define FND_LZ_BLANK_EN to enable leading-zero suppression.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  output logic [7:0]  seg,
  output logic [7:0]  row,
  output logic        frame_start
);

  localparam int CNT_MAX_DB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_DB > 2) ? CNT_MAX_DB : 2;
  localparam int CNT_W      = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0]       IDX_LAST   = 3'(ROW_COUNT - 1);

  scan_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      snap_digits_q, snap_digits_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;

  logic             snap_load;
  logic [31:0]      src_digits;
  logic [7:0]       src_dp;
  logic [3:0]       enc_code;
  logic             enc_dp;
  logic [7:0]       enc_seg;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_load = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ON;
          idx_d     = '0;
          cnt_d     = '0;
          snap_load = 1'b1;
        end
        ST_ON: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) begin
              idx_d     = idx_q + 3'd1;
              snap_load = (idx_q == IDX_LAST);
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d   = ST_ON;
            cnt_d     = '0;
            idx_d     = idx_q + 3'd1;
            snap_load = (idx_q == IDX_LAST);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // On a snapshot edge the encoder sees the incoming values so seg is valid on frame_start.
  always_comb begin
    src_digits    = snap_load ? digits : snap_digits_q;
    src_dp        = snap_load ? dp : snap_dp_q;
    enc_code      = src_digits[{idx_d, 2'b00} +: 4];
    enc_dp        = src_dp[idx_d];
    snap_digits_d = en ? src_digits : '0;
    snap_dp_d     = en ? src_dp : '0;
  end

  seg7_encode u_seg7_encode (
    .code (enc_code),
    .dp   (enc_dp),
    .seg  (enc_seg)
  );

`ifdef FND_LZ_BLANK_EN
  logic [ROW_COUNT-1:0] lz_q, lz_d, lz_src;

  always_comb begin
    lz_src = snap_load ? lz_mask(digits, dp) : lz_q;
    lz_d   = en ? lz_src : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_q <= '0;
    end else begin
      lz_q <= lz_d;
    end
  end
`endif

  always_comb begin
    row_d = '0;
    seg_d = SEG_OFF;
    fs_d  = 1'b0;
    if (state_d == ST_ON) begin
      row_d = 8'b1 << idx_d;
      seg_d = enc_seg;
      fs_d  = snap_load;
`ifdef FND_LZ_BLANK_EN
      if (lz_src[idx_d]) begin
        seg_d = SEG_OFF;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      row_q         <= '0;
      seg_q         <= '0;
      fs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      row_q         <= row_d;
      seg_q         <= seg_d;
      fs_q          <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign row         = row_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - Directed bench for fnd_scan_ctrl (gap and no-gap builds).
module tb_fnd_scan_ctrl;

  localparam int DW = 4;
  localparam int BL = 2;

  // Expected seg per digit, byte d = digit d
  localparam logic [63:0] E_COUNT = 64'hE0BEB666F2DA60FC;
  localparam logic [63:0] E_NB    = 64'hE0BEB666F2DB60FC;
`ifdef FND_LZ_BLANK_EN
  localparam logic [63:0] E_NINE  = 64'h00000000000000F6;
  localparam logic [63:0] E_LZ    = 64'h000000000060DAFC;
`else
  localparam logic [63:0] E_NINE  = 64'hFCFCFCFCFCFCFCF6;
  localparam logic [63:0] E_LZ    = 64'hFCFCFCFCFC60DAFC;
`endif

  logic        clk;
  logic        rst_n;
  logic        en, en2;
  logic [31:0] digits, digits2;
  logic [7:0]  dp, dp2;
  logic [7:0]  seg, seg2;
  logic [7:0]  row, row2;
  logic        frame_start, frame_start2;

  int n_checks;
  int n_pass;

  fnd_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digits      (digits),
    .dp          (dp),
    .seg         (seg),
    .row         (row),
    .frame_start (frame_start)
  );

  fnd_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(0)) u_dut_nb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en2),
    .digits      (digits2),
    .dp          (dp2),
    .seg         (seg2),
    .row         (row2),
    .frame_start (frame_start2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the edge that starts digit d_from ON; leaves at the start of the next digit.
  task automatic frame_chk(input logic [63:0] exp_segs, input int d_from, input int d_to);
    logic [7:0] r;
    for (int d = d_from; d <= d_to; d++) begin
      r = 8'h01 << d;
      for (int c = 0; c < DW; c++) begin
        check_eq($sformatf("row d%0d c%0d", d, c), 32'(row), 32'(r));
        check_eq($sformatf("seg d%0d c%0d", d, c), 32'(seg), 32'(exp_segs[8*d +: 8]));
        check_eq($sformatf("fs d%0d c%0d", d, c), 32'(frame_start), 32'(d == 0 && c == 0));
        tick();
      end
      for (int c = 0; c < BL; c++) begin
        check_eq($sformatf("blank row d%0d c%0d", d, c), 32'(row), 32'h0);
        check_eq($sformatf("blank seg d%0d c%0d", d, c), 32'(seg), 32'h0);
        check_eq($sformatf("blank fs d%0d c%0d", d, c), 32'(frame_start), 32'h0);
        tick();
      end
    end
  endtask

  initial begin
    logic [7:0] r2;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    en       = 1'b1;
    digits   = 32'h76543210;
    dp       = 8'h00;
    en2      = 1'b0;
    digits2  = 32'h76543210;
    dp2      = 8'h04;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_eq("reset row", 32'(row), 32'h0);
    check_eq("reset seg", 32'(seg), 32'h0);
    check_eq("reset fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    tick();

    // Two full frames back to back: frame_start every 48 cycles
    frame_chk(E_COUNT, 0, 7);
    frame_chk(E_COUNT, 0, 7);

    // Inputs changed during digit 3 stay invisible until the next frame
    frame_chk(E_COUNT, 0, 2);
    digits = 32'h00000009;
    frame_chk(E_COUNT, 3, 7);
    frame_chk(E_NINE, 0, 4);

    // Drop en during digit 5 ON
    tick();
    en = 1'b0;
    tick();
    check_eq("en drop row", 32'(row), 32'h0);
    check_eq("en drop seg", 32'(seg), 32'h0);
    check_eq("en drop fs", 32'(frame_start), 32'h0);
    tick();
    check_eq("idle row", 32'(row), 32'h0);
    check_eq("idle seg", 32'(seg), 32'h0);
    digits = 32'h76543210;
    en = 1'b1;
    tick();
    frame_chk(E_COUNT, 0, 7);

    // Asynchronous reset mid-frame
    frame_chk(E_COUNT, 0, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("async rst row", 32'(row), 32'h0);
    check_eq("async rst seg", 32'(seg), 32'h0);
    check_eq("async rst fs", 32'(frame_start), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    frame_chk(E_COUNT, 0, 0);

    // Leading zeros
    en = 1'b0;
    digits = 32'h00000120;
    tick();
    en = 1'b1;
    tick();
    frame_chk(E_LZ, 0, 7);
    en = 1'b0;
    tick();

    // No blanking gap build
    en2 = 1'b1;
    tick();
    for (int d = 0; d < 8; d++) begin
      r2 = 8'h01 << d;
      for (int c = 0; c < DW; c++) begin
        check_eq($sformatf("nb row d%0d c%0d", d, c), 32'(row2), 32'(r2));
        check_eq($sformatf("nb seg d%0d c%0d", d, c), 32'(seg2), 32'(E_NB[8*d +: 8]));
        check_eq($sformatf("nb fs d%0d c%0d", d, c), 32'(frame_start2), 32'(d == 0 && c == 0));
        tick();
      end
    end
    check_eq("nb wrap row", 32'(row2), 32'h01);
    check_eq("nb wrap fs", 32'(frame_start2), 32'h1);
    en2 = 1'b0;
    tick();
    check_eq("nb off row", 32'(row2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
